// File: rtl/i2c_master_if.sv
// Command/status handshake between the system-side controller and i2c_master.
interface i2c_master_if;
   logic       start;
   logic       rw;
   logic [6:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       busy;
   logic       done;
   logic       ack_err;

   modport master (input start, rw, addr, wdata, output rdata, busy, done, ack_err);
   modport slave  (output start, rw, addr, wdata, input rdata, busy, done, ack_err);
endinterface

// File: rtl/i2c_master.sv
// Single-byte I2C bus master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// SCL is push-pull; SDA is open-drain (driven low or released only).
module i2c_master #(
   parameter int CLK_DIV = 4
) (
   input  logic         clk,
   input  logic         rst,
   i2c_master_if.master cmd,
   output logic         scl,
   inout  wire          sda
);
   localparam int CW = $clog2(CLK_DIV);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ACK1, S_WDATA, S_ACK2, S_RDATA, S_MACK, S_STOP, S_DONE
   } state_t;

   state_t         r_state;
   logic [CW-1:0]  r_cnt;
   logic [1:0]     r_q;
   logic [2:0]     r_bit;
   logic           r_rw;
   logic [6:0]     r_addr;
   logic [7:0]     r_wdata;
   logic [7:0]     r_shift;
   logic           r_nack;
   logic           r_scl;
   logic           r_sda_low;
   logic           r_busy;
   logic           r_done;
   logic           r_ack_err;
   logic [7:0]     r_rdata;

   logic           w_tick;
   logic           w_sample;
   logic           w_slot_end;
   logic [7:0]     w_addr_byte;
   logic [2:0]     w_bit_idx;
   logic           w_scl;
   logic           w_sda_low;
   logic           w_sda_in;

   assign w_tick      = (r_cnt == CW'(CLK_DIV - 1));
   assign w_sample    = w_tick && (r_q == 2'd2);
   assign w_slot_end  = w_tick && (r_q == 2'd3);
   assign w_addr_byte = {r_addr, r_rw};
   assign w_bit_idx   = 3'd7 - r_bit;
   assign w_sda_in    = sda;

   assign sda         = r_sda_low ? 1'b0 : 1'bz;
   assign scl         = r_scl;
   assign cmd.rdata   = r_rdata;
   assign cmd.busy    = r_busy;
   assign cmd.done    = r_done;
   assign cmd.ack_err = r_ack_err;

   // START and STOP each span two slots: START opens with a bus-free slot,
   // STOP closes with one, giving 22-slot (full) and 13-slot (address NACK) frames.
   always_comb begin
      w_scl     = 1'b1;
      w_sda_low = 1'b0;
      case (r_state)
         S_START: w_sda_low = (r_bit == 3'd1) && r_q[1];
         S_ADDR: begin
            w_scl     = r_q[1];
            w_sda_low = ~w_addr_byte[w_bit_idx];
         end
         S_WDATA: begin
            w_scl     = r_q[1];
            w_sda_low = ~r_wdata[w_bit_idx];
         end
         S_ACK1, S_ACK2, S_RDATA, S_MACK: w_scl = r_q[1];
         S_STOP: if (r_bit == 3'd0) begin
            w_scl     = (r_q != 2'd0);
            w_sda_low = ~r_q[1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_q       <= '0;
         r_bit     <= '0;
         r_rw      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_shift   <= '0;
         r_nack    <= 1'b0;
         r_scl     <= 1'b1;
         r_sda_low <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ack_err <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_scl     <= w_scl;
         r_sda_low <= w_sda_low;
         r_done    <= 1'b0;
         case (r_state)
            S_IDLE: if (cmd.start) begin
               r_rw      <= cmd.rw;
               r_addr    <= cmd.addr;
               r_wdata   <= cmd.wdata;
               r_nack    <= 1'b0;
               r_ack_err <= 1'b0;
               r_busy    <= 1'b1;
               r_cnt     <= '0;
               r_q       <= '0;
               r_bit     <= '0;
               r_state   <= S_START;
            end
            S_DONE: r_state <= S_IDLE;
            default: begin
               r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
               if (w_tick) r_q <= r_q + 1'b1;
               if (w_sample) begin
                  if ((r_state == S_ACK1 || r_state == S_ACK2) && w_sda_in) r_nack <= 1'b1;
                  if (r_state == S_RDATA) r_shift <= {r_shift[6:0], w_sda_in};
               end
               if (w_slot_end) begin
                  r_bit <= r_bit + 1'b1;
                  case (r_state)
                     S_START: if (r_bit == 3'd1) begin
                        r_bit   <= '0;
                        r_state <= S_ADDR;
                     end
                     S_ADDR: if (r_bit == 3'd7) begin
                        r_bit   <= '0;
                        r_state <= S_ACK1;
                     end
                     S_ACK1: begin
                        r_bit   <= '0;
                        r_state <= r_nack ? S_STOP : (r_rw ? S_RDATA : S_WDATA);
                     end
                     S_WDATA: if (r_bit == 3'd7) begin
                        r_bit   <= '0;
                        r_state <= S_ACK2;
                     end
                     S_RDATA: if (r_bit == 3'd7) begin
                        r_bit   <= '0;
                        r_state <= S_MACK;
                     end
                     S_ACK2, S_MACK: begin
                        r_bit   <= '0;
                        r_state <= S_STOP;
                     end
                     S_STOP: if (r_bit == 3'd1) begin
                        r_bit     <= '0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_ack_err <= r_nack;
                        if (r_rw && !r_nack) r_rdata <= r_shift;
                        r_state   <= S_DONE;
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end
endmodule
